muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the single-cycle RV32I core. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over multiple cycles, using radix-2 shift-add for multiplies and restoring division for divides. The control logic issues an operation through a start/valid handshake and stalls the pipeline while `MD_Busy` is high. The result returns on the same write-back path as `ALU_Out`.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide (shift-add / restoring divide)
// Optional MD_EARLY_OUT_EN: special cases bypass CALC and finish in DONE.
// Revision: 1.0
// ============================================================================
module muldiv_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              MD_Start,
  input  logic [2:0]        MD_OP,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  input  logic              MD_Flush,
  output logic              MD_Busy,
  output logic              MD_Valid,
  output logic [DWIDTH-1:0] MD_Out
);

  localparam int            CW     = $clog2(DWIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(DWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  logic                  busy_q, valid_q;
  logic [DWIDTH-1:0]     out_q;
  logic [CW-1:0]         cnt_q;
  logic [2*DWIDTH-1:0]   acc_q;
  logic [DWIDTH-1:0]     a_q, b_q;
  logic [2:0]            op_q;
  logic                  neg_a_q, neg_b_q;

  logic                  in_sgn_a, in_sgn_b, in_neg_a, in_neg_b;
  logic [DWIDTH-1:0]     in_mag_a, in_mag_b;
  logic [DWIDTH:0]       mul_sum, div_shrem;
  logic                  div_ge;
  logic [DWIDTH-1:0]     div_rem;
  logic [2*DWIDTH-1:0]   acc_d, prod_fix;
  logic [DWIDTH-1:0]     quo_fix, rem_fix, result_d;
  logic                  early_d;
  logic [DWIDTH-1:0]     early_res_d;

  // Reset asserts asynchronously and releases synchronously to Clk.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    in_sgn_a = (MD_OP == 3'b001) || (MD_OP == 3'b010) ||
               (MD_OP == 3'b100) || (MD_OP == 3'b110);
    in_sgn_b = (MD_OP == 3'b001) || (MD_OP == 3'b100) || (MD_OP == 3'b110);
    in_neg_a = in_sgn_a & MD_In_A[DWIDTH-1];
    in_neg_b = in_sgn_b & MD_In_B[DWIDTH-1];
    in_mag_a = in_neg_a ? -MD_In_A : MD_In_A;
    in_mag_b = in_neg_b ? -MD_In_B : MD_In_B;
  end

  // One iteration: multiply keeps the product in acc, multiplier in b_q;
  // divide keeps {remainder, quotient} in acc and shifts dividend bits from a_q.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + {1'b0, a_q};
    div_shrem = {acc_q[2*DWIDTH-1:DWIDTH], a_q[DWIDTH-1]};
    div_ge    = div_shrem >= {1'b0, b_q};
    div_rem   = div_ge ? DWIDTH'(div_shrem - {1'b0, b_q}) : div_shrem[DWIDTH-1:0];
    if (op_q[2])      acc_d = {div_rem, acc_q[DWIDTH-2:0], div_ge};
    else if (b_q[0])  acc_d = {mul_sum, acc_q[DWIDTH-1:1]};
    else              acc_d = {1'b0, acc_q[2*DWIDTH-1:1]};

    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_d : acc_d;
    quo_fix  = ((neg_a_q ^ neg_b_q) && (b_q != '0)) ? -acc_d[DWIDTH-1:0]
                                                    : acc_d[DWIDTH-1:0];
    rem_fix  = neg_a_q ? -acc_d[2*DWIDTH-1:DWIDTH] : acc_d[2*DWIDTH-1:DWIDTH];
    case (op_q)
      3'b000:                 result_d = prod_fix[DWIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod_fix[2*DWIDTH-1:DWIDTH];
      3'b100, 3'b101:         result_d = quo_fix;
      default:                result_d = rem_fix;
    endcase
  end

`ifdef MD_EARLY_OUT_EN
  always_comb begin
    early_d     = 1'b0;
    early_res_d = '0;
    if (MD_OP[2] && (MD_In_B == '0)) begin
      early_d     = 1'b1;
      early_res_d = MD_OP[1] ? MD_In_A : '1;
    end else if (MD_OP[2] && in_sgn_a && (MD_In_B == '1) &&
                 (MD_In_A == {1'b1, {(DWIDTH-1){1'b0}}})) begin
      early_d     = 1'b1;
      early_res_d = MD_OP[1] ? '0 : MD_In_A;
    end else if (!MD_OP[2] && ((MD_In_A == '0) || (MD_In_B == '0))) begin
      early_d     = 1'b1;
    end
  end
`else
  assign early_d     = 1'b0;
  assign early_res_d = '0;
`endif

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (MD_Start && !MD_Flush) begin
            op_q    <= MD_OP;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            a_q     <= in_mag_a;
            b_q     <= in_mag_b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (early_d) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              out_q   <= early_res_d;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (MD_Flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (op_q[2]) a_q <= {a_q[DWIDTH-2:0], 1'b0};
            else         b_q <= {1'b0, b_q[DWIDTH-1:1]};
            if (cnt_q == C_LAST) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              out_q   <= result_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign MD_Busy  = busy_q;
  assign MD_Valid = valid_q;
  assign MD_Out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;

  localparam int LAT_FULL = 33;
`ifdef MD_EARLY_OUT_EN
  localparam int LAT_SPEC = 1;
`else
  localparam int LAT_SPEC = 33;
`endif

  logic        Clk     = 1'b0;
  logic        Reset_N = 1'b1;
  logic        MD_Start = 1'b0;
  logic [2:0]  MD_OP    = 3'b000;
  logic [31:0] MD_In_A  = '0;
  logic [31:0] MD_In_B  = '0;
  logic        MD_Flush = 1'b0;
  logic        MD_Busy, MD_Valid;
  logic [31:0] MD_Out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] res;
  int          lat, nvalid;
  logic        busy_ok;

  muldiv_unit #(.DWIDTH(32)) dut (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .MD_Start (MD_Start),
    .MD_OP    (MD_OP),
    .MD_In_A  (MD_In_A),
    .MD_In_B  (MD_In_B),
    .MD_Flush (MD_Flush),
    .MD_Busy  (MD_Busy),
    .MD_Valid (MD_Valid),
    .MD_Out   (MD_Out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op, then waits (bounded) for MD_Valid; operands are scrambled
  // after the start cycle so only the start-cycle values may matter.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int l, output logic bok, output int nv);
    @(posedge Clk); #1;
    MD_OP = op; MD_In_A = a; MD_In_B = b; MD_Start = 1'b1;
    @(posedge Clk); #1;
    MD_Start = 1'b0; MD_In_A = ~a; MD_In_B = ~b; MD_OP = ~op;
    l   = 1;
    bok = MD_Busy;
    while (!MD_Valid && l < 200) begin
      @(posedge Clk); #1;
      l++;
      if (!MD_Busy) bok = 1'b0;
    end
    r  = MD_Out;
    nv = MD_Valid ? 1 : 0;
    @(posedge Clk); #1;
    if (MD_Valid) nv++;
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    run_op(op, a, b, res, lat, busy_ok, nvalid);
    check(tag, {32'd0, res}, {32'd0, exp});
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 Reset_N = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy",  MD_Busy,  0);
    check("rst_valid", MD_Valid, 0);
    check("rst_out",   MD_Out,   0);
    Reset_N = 1'b1;
    repeat (3) @(posedge Clk);

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, res, lat, busy_ok, nvalid);
    check("mul",        res,     32'hFFFF_FFEB);
    check("mul_lat",    lat,     LAT_FULL);
    check("mul_busy",   busy_ok, 1);
    check("mul_pulses", nvalid,  1);
    check("idle_busy",  MD_Busy, 0);

    op_check("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_FULL);
    op_check("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FULL);
    op_check("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, LAT_FULL);
    op_check("div_n",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_FULL);
    op_check("rem_n",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_FULL);
    op_check("div_nn", 3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h0000_0004, LAT_FULL);
    op_check("divu",   3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, LAT_FULL);
    op_check("div0",   3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, LAT_SPEC);
    op_check("rem0",   3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, LAT_SPEC);
    op_check("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
    op_check("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPEC);
    op_check("remu",   3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, LAT_FULL);

    // Flush at CALC cycle 10: output must keep the REMU result.
    @(posedge Clk); #1;
    MD_OP = 3'b011; MD_In_A = 32'hFFFF_FFFF; MD_In_B = 32'hFFFF_FFFF; MD_Start = 1'b1;
    @(posedge Clk); #1;
    MD_Start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    MD_Flush = 1'b1;
    @(posedge Clk); #1;
    MD_Flush = 1'b0;
    check("flush_busy",  MD_Busy,  0);
    check("flush_valid", MD_Valid, 0);
    nvalid = 0;
    repeat (40) begin @(posedge Clk); #1; if (MD_Valid) nvalid++; end
    check("flush_pulses", nvalid, 0);
    check("flush_out",    MD_Out, 32'h0000_000F);

    // Start together with flush in IDLE is dropped.
    MD_OP = 3'b000; MD_In_A = 32'd9; MD_In_B = 32'd9; MD_Start = 1'b1; MD_Flush = 1'b1;
    @(posedge Clk); #1;
    MD_Start = 1'b0; MD_Flush = 1'b0;
    check("flushstart_busy", MD_Busy, 0);

    // Start pulsed mid-CALC is ignored.
    MD_OP = 3'b000; MD_In_A = 32'd3; MD_In_B = 32'd4; MD_Start = 1'b1;
    @(posedge Clk); #1;
    MD_Start = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    MD_In_A = 32'd5; MD_In_B = 32'd5; MD_Start = 1'b1;
    @(posedge Clk); #1;
    MD_Start = 1'b0;
    nvalid = 0;
    repeat (80) begin @(posedge Clk); #1; if (MD_Valid) nvalid++; end
    check("ign_pulses", nvalid, 1);
    check("ign_out",    MD_Out, 32'd12);

    // Asynchronous reset in the middle of CALC.
    MD_OP = 3'b011; MD_In_A = 32'h1234_5678; MD_In_B = 32'h9ABC_DEF0; MD_Start = 1'b1;
    @(posedge Clk); #1;
    MD_Start = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    Reset_N = 1'b0;
    #1;
    check("arst_busy",  MD_Busy,  0);
    check("arst_valid", MD_Valid, 0);
    check("arst_out",   MD_Out,   0);
    repeat (2) @(posedge Clk);
    #1 Reset_N = 1'b1;
    repeat (3) @(posedge Clk);

    op_check("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
